result_display_seq: RTL and testbench

//  Display sequencer downstream of the systolic-array result FIFO; drives the two-digit SSD path.

---
 rtl/result_display_seq.sv | 106 ++++++++++
 tb/tb_result_display_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_display_seq.sv
// Display sequencer: waits for a full result matrix in the FIFO, then shows
// each element for a dwell period with a blank gap, popping one per element.
module result_display_seq #(
    parameter int width_p        = 8,
    parameter int num_elems_p    = 4,
    parameter int dwell_cycles_p = 60_000_000,
    parameter int blank_cycles_p = 1_200_000
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           full_i,
    input  logic                           valid_i,
    input  logic [width_p-1:0]             data_i,
    input  logic                           skip_i,
    output logic                           yumi_o,
    output logic [width_p-1:0]             data_o,
    output logic [$clog2(num_elems_p):0]   index_o,
    output logic                           display_o,
    output logic                           blank_o,
    output logic                           done_o
);

    localparam int max_cyc_lp =
        (dwell_cycles_p > blank_cycles_p) ? dwell_cycles_p : blank_cycles_p;
    localparam int cnt_w_lp = $clog2(max_cyc_lp);
    localparam int idx_w_lp = $clog2(num_elems_p) + 1;

    typedef enum logic [1:0] {
        idle_s,
        show_s,
        gap_s
    } state_e;

    state_e                state;
    logic [cnt_w_lp-1:0]   cnt;
    logic                  terminal;
    logic                  last;
    logic                  gap_end;

    // One counter serves both dwell and gap; it is reloaded on every state entry.
    assign terminal = (state == show_s) &
                      ((cnt == cnt_w_lp'(dwell_cycles_p - 1)) | skip_i);
    assign gap_end  = (cnt == cnt_w_lp'(blank_cycles_p - 1));
    assign last     = (index_o == idx_w_lp'(num_elems_p - 1));
    assign yumi_o   = terminal & valid_i & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= idle_s;
            cnt       <= '0;
            data_o    <= '0;
            index_o   <= '0;
            display_o <= 1'b0;
            blank_o   <= 1'b1;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                idle_s: begin
                    if (full_i && valid_i) begin
                        state     <= show_s;
                        data_o    <= data_i;
                        index_o   <= '0;
                        cnt       <= '0;
                        display_o <= 1'b1;
                        blank_o   <= 1'b0;
                    end
                end
                show_s: begin
                    if (terminal) begin
                        cnt     <= '0;
                        blank_o <= 1'b1;
                        if (valid_i && !last) begin
                            state <= gap_s;
                        end else begin
                            // A head that vanished mid-dwell ends the run silently.
                            state     <= idle_s;
                            display_o <= 1'b0;
                            done_o    <= valid_i;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                gap_s: begin
                    if (gap_end) begin
                        cnt <= '0;
                        if (valid_i) begin
                            state   <= show_s;
                            data_o  <= data_i;
                            index_o <= index_o + 1'b1;
                            blank_o <= 1'b0;
                        end else begin
                            state     <= idle_s;
                            display_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= idle_s;
            endcase
        end
    end

endmodule

// File: tb/tb_result_display_seq.sv
// Directed bench for result_display_seq with a small FIFO model feeding it.
// Short dwell/blank parameters keep each scenario to a few dozen cycles.
module tb_result_display_seq;

    logic       clk;
    logic       reset;
    logic       full;
    logic       valid;
    logic [7:0] data;
    logic       skip;
    logic       yumi;
    logic [7:0] shown;
    logic [2:0] index;
    logic       display;
    logic       blank;
    logic       done;

    int checks = 0;
    int errors = 0;
    int vmode  = 0;
    logic [7:0] q[$];

    result_display_seq #(
        .width_p(8),
        .num_elems_p(4),
        .dwell_cycles_p(8),
        .blank_cycles_p(2)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .full_i(full),
        .valid_i(valid),
        .data_i(data),
        .skip_i(skip),
        .yumi_o(yumi),
        .data_o(shown),
        .index_o(index),
        .display_o(display),
        .blank_o(blank),
        .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive FIFO-side inputs, sample yumi, pop on the edge.
    task automatic tick(output logic y);
        full  = (q.size() == 4);
        valid = (vmode == 0) ? (q.size() != 0) : (vmode == 1);
        data  = (q.size() != 0) ? q[0] : 8'h00;
        #1 y = yumi;
        @(posedge clk);
        if (y && q.size() != 0) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic preload();
        q.delete();
        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        q.push_back(8'h44);
    endtask

    task automatic do_reset();
        logic y;
        reset = 1'b1;
        tick(y);
        check("reset_yumi", y, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic y;
        int npop;
        int ndone;
        reset = 1'b1;
        skip  = 1'b0;
        full  = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        preload();
        @(negedge clk);

        // reset held with a full FIFO
        for (int i = 0; i < 2; i++) begin
            tick(y);
            check("rst_yumi", y, 0);
        end
        check("rst_data", shown, 8'h00);
        check("rst_index", index, 0);
        check("rst_display", display, 0);
        check("rst_blank", blank, 1);
        check("rst_done", done, 0);

        // full pass
        reset = 1'b0;
        npop  = 0;
        ndone = 0;
        for (int t = 0; t < 50; t++) begin
            tick(y);
            if (y) begin
                check("pass_pop_tick", t, 8 + 10 * npop);
                npop++;
            end
            if (done) begin
                check("pass_done_tick", t, 38);
                ndone++;
            end
            if (t == 0) begin
                check("pass_d0", shown, 8'h11);
                check("pass_i0", index, 0);
                check("pass_disp0", display, 1);
                check("pass_blank0", blank, 0);
            end
            if (t == 8 || t == 9) begin
                check("pass_gap_blank", blank, 1);
                check("pass_gap_disp", display, 1);
            end
            if (t == 10) begin
                check("pass_d1", shown, 8'h22);
                check("pass_i1", index, 1);
                check("pass_blank1", blank, 0);
            end
            if (t == 30) begin
                check("pass_d3", shown, 8'h44);
                check("pass_i3", index, 3);
            end
            if (t == 38) begin
                check("pass_end_disp", display, 0);
                check("pass_end_blank", blank, 1);
                check("pass_end_hold", shown, 8'h44);
            end
        end
        check("pass_npop", npop, 4);
        check("pass_ndone", ndone, 1);

        // valid but not full: never starts
        do_reset();
        vmode = 1;
        npop  = 0;
        for (int t = 0; t < 100; t++) begin
            tick(y);
            if (y) npop++;
        end
        check("nf_npop", npop, 0);
        check("nf_display", display, 0);
        check("nf_blank", blank, 1);
        vmode = 0;

        // skip on third SHOW cycle, then a skip in GAP that must be ignored
        preload();
        do_reset();
        npop = 0;
        for (int t = 0; t < 16; t++) begin
            skip = (t == 3 || t == 4);
            tick(y);
            skip = 1'b0;
            if (y) begin
                check("skip_pop_tick", t, (npop == 0) ? 3 : 13);
                npop++;
            end
            if (t == 3) begin
                check("skip_gap_blank", blank, 1);
                check("skip_gap_disp", display, 1);
            end
            if (t == 4) check("skip_gap_yumi", y, 0);
            if (t == 5) begin
                check("skip_d1", shown, 8'h22);
                check("skip_i1", index, 1);
                check("skip_blank1", blank, 0);
            end
        end
        check("skip_npop", npop, 2);

        // FIFO drains after the second pop
        preload();
        do_reset();
        npop  = 0;
        ndone = 0;
        for (int t = 0; t < 40; t++) begin
            vmode = (npop >= 2) ? 2 : 0;
            tick(y);
            if (y) begin
                check("drain_pop_tick", t, 8 + 10 * npop);
                npop++;
            end
            if (done) ndone++;
            if (t == 19) check("drain_gap_disp", display, 1);
            if (t == 20) begin
                check("drain_idle_disp", display, 0);
                check("drain_idle_blank", blank, 1);
            end
        end
        check("drain_npop", npop, 2);
        check("drain_ndone", ndone, 0);
        vmode = 0;

        // reset during SHOW of element 2, coinciding with a skip
        preload();
        do_reset();
        for (int t = 0; t < 26; t++) begin
            reset = (t == 25);
            skip  = (t == 25);
            tick(y);
            if (t == 24) begin
                check("mid_d2", shown, 8'h33);
                check("mid_i2", index, 2);
            end
            if (t == 25) begin
                check("mid_rst_yumi", y, 0);
                check("mid_rst_data", shown, 8'h00);
                check("mid_rst_index", index, 0);
                check("mid_rst_disp", display, 0);
                check("mid_rst_blank", blank, 1);
            end
        end
        reset = 1'b0;
        skip  = 1'b0;
        check("mid_qsize", q.size(), 2);
        for (int t = 0; t < 5; t++) tick(y);
        check("mid_idle_disp", display, 0);
        check("mid_qsize_after", q.size(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
